// File: rtl/ika87ad_irq_filter_bank.sv
// rtl/ika87ad_irq_filter_bank.sv - multi-channel interrupt pin filter with edge/level detect and sticky pending
// Shared prescaled sample strobe, per-channel all-equal debounce with hysteresis.
module ika87ad_irq_filter_bank #(
   parameter int CH    = 4,
   parameter int DIV   = 36,
   parameter int CNTW  = 6,
   parameter int DEPTH = 3
) (
   input  logic              i_EMUCLK,
   input  logic              i_MRST_n,
   input  logic              i_CNTTICK,
   input  logic [CH-1:0]     i_IS,
   input  logic [2*CH-1:0]   i_MODE,
   input  logic [CH-1:0]     i_ACK,
   output logic [CH-1:0]     o_LEVEL,
   output logic [CH-1:0]     o_DET,
   output logic [CH-1:0]     o_PEND,
   output logic              o_ANY
);

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);

   logic [CNTW-1:0]            cnt_q, cnt_d;
   logic                       strobe;
   logic [CH-1:0][DEPTH-1:0]   sr_q, sr_d;
   logic [CH-1:0]              level_q, level_d;
   logic [CH-1:0]              det_q, det_d;
   logic [CH-1:0]              pend_q, pend_d;
   logic                       any_q, any_d;
   logic [CH-1:0]              rise, fall, set_n;

   always_comb begin
      strobe = i_CNTTICK && (cnt_q == CNT_LAST);
      cnt_d  = cnt_q;
      if (i_CNTTICK) begin
         cnt_d = strobe ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      sr_d    = sr_q;
      level_d = level_q;
      det_d   = '0;
      pend_d  = pend_q;
      rise    = '0;
      fall    = '0;
      set_n   = '0;
      for (int n = 0; n < CH; n++) begin
         if (strobe) begin
            sr_d[n] = {sr_q[n][DEPTH-2:0], i_IS[n]};
         end
         // Mixed history holds the previous filtered level.
         if (&sr_q[n]) begin
            level_d[n] = 1'b1;
         end else if (~|sr_q[n]) begin
            level_d[n] = 1'b0;
         end
         rise[n] = ~level_q[n] & level_d[n];
         fall[n] = level_q[n] & ~level_d[n];
         case (i_MODE[2*n +: 2])
            2'b00:   det_d[n] = rise[n];
            2'b01:   det_d[n] = fall[n];
            2'b10:   det_d[n] = rise[n] | fall[n];
            default: det_d[n] = 1'b0;
         endcase
         // A set condition beats an acknowledge in the same cycle.
         set_n[n] = det_q[n] | ((i_MODE[2*n +: 2] == 2'b11) & level_q[n]);
         if (set_n[n]) begin
            pend_d[n] = 1'b1;
         end else if (i_ACK[n]) begin
            pend_d[n] = 1'b0;
         end
      end
      any_d = |pend_q;
   end

   always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         cnt_q   <= '0;
         sr_q    <= '0;
         level_q <= '0;
         det_q   <= '0;
         pend_q  <= '0;
         any_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         level_q <= level_d;
         det_q   <= det_d;
         pend_q  <= pend_d;
         any_q   <= any_d;
      end
   end

   assign o_LEVEL = level_q;
   assign o_DET   = det_q;
   assign o_PEND  = pend_q;
   assign o_ANY   = any_q;

endmodule

// File: doc/ika87ad_irq_filter_bank.md
Name: ika87ad_irq_filter_bank

Overview:
- Multi-channel successor to the single-channel INT pin sampler.
- Each of CH external interrupt inputs is sampled on a shared prescaled strobe and debounced with a DEPTH-deep majority-free (all-equal) filter that holds state in between (hysteresis).
- Each channel raises a one-cycle detect pulse on a per-channel selectable edge or level condition, and keeps a sticky pending flag until it is acknowledged.
- Sits between the CPU pins and the interrupt flag logic.

Parameters:
- CH, 4, number of interrupt channels (1..16).
- DIV, 36, sample strobe period in i_CNTTICK ticks (1..2^CNTW).
- CNTW, 6, prescaler counter width.
- DEPTH, 3, filter shift-register depth, i.e. consecutive equal samples required (2..8).

Ports:
- i_EMUCLK  in  1  system clock, all state updates on rising edge.
- i_MRST_n  in  1  asynchronous active-low reset.
- i_CNTTICK  in  1  prescaler count enable, one-cycle pulses.
- i_IS  in  CH  raw interrupt inputs, already synchronised to i_EMUCLK.
- i_MODE  in  2*CH  per-channel mode in bits [2n+1:2n]: 00 rising, 01 falling, 10 both edges, 11 level-high.
- i_ACK  in  CH  per-channel pending clear, one-cycle pulse.
- o_LEVEL  out  CH  filtered input level.
- o_DET  out  CH  one-cycle detect pulse.
- o_PEND  out  CH  sticky pending flags.
- o_ANY  out  1  OR of o_PEND, registered.

Behaviour:
- Reset (async, i_MRST_n=0): prescaler=0, all shift registers=0, o_LEVEL=0, o_DET=0, o_PEND=0, o_ANY=0. Reset asserted mid-operation discards all in-flight samples; after release, counting restarts from 0.
- Prescaler: on i_CNTTICK, cnt <= (cnt==DIV-1) ? 0 : cnt+1.
  - strobe = i_CNTTICK && cnt==DIV-1.
  - DIV=1 gives a strobe on every tick.
  - Without i_CNTTICK, cnt holds.
- Sampling: on strobe, sr[n] <= {sr[n][DEPTH-2:0], i_IS[n]} for every channel simultaneously.
- Filter: evaluated every clock from sr.
  - sr all ones -> o_LEVEL[n] <= 1.
  - sr all zeros -> o_LEVEL[n] <= 0.
  - Otherwise hold.
  - Timing: o_LEVEL changes on the edge after the strobe edge that completed the run. Latency from the first sampled-high strobe is DEPTH-1 further strobes plus 1 clock.
- Detect: registered. On the same edge o_LEVEL[n] updates, o_DET[n] <= 1 for one cycle when:
  - mode 00: 0->1 transition.
  - mode 01: 1->0 transition.
  - mode 10: either transition.
  - Otherwise o_DET[n] <= 0.
  - Mode 11 never pulses o_DET.
- Pending, per channel, evaluated each clock:
  - set_n = o_DET[n] || (mode==11 && o_LEVEL[n]).
  - If set_n, o_PEND[n] <= 1.
  - Else if i_ACK[n], o_PEND[n] <= 0.
  - Set wins over a simultaneous ack. In level mode the flag re-asserts the cycle after ack while o_LEVEL stays high.
- o_ANY <= |o_PEND, one cycle behind o_PEND.
- Mode changes take effect the next clock. Changing mode does not itself generate o_DET and does not clear o_PEND.
- Channels are fully independent. Simultaneous detects on several channels all set their flags in the same cycle.
- i_ACK on a channel that is not pending: no effect.

Test Plan (DIV=4, DEPTH=3, CH=4 unless stated; i_CNTTICK held 1):
1. Reset, then hold i_IS=0. Expect all outputs 0; cnt cycles 0,1,2,3,0; strobe every 4th clock.
2. ch0 mode 00: raise i_IS[0] before strobe k. Expect o_LEVEL[0]=1 one clock after strobe k+2, o_DET[0]=1 for exactly that cycle, o_PEND[0]=1 the next clock, o_ANY the clock after. Pulse i_ACK[0] -> o_PEND[0]=0.
3. Glitch rejection: i_IS[1] high for 2 strobes then low (mode 10). Expect o_LEVEL[1], o_DET[1], o_PEND[1] stay 0. Then pattern 1,1,1,0,1 across strobes: o_LEVEL rises once and holds through the single 0; exactly one o_DET.
4. ch2 mode 01: filtered level goes 1 then 0. Expect no pulse on the rise and one o_DET on the fall. In mode 10 the same stimulus gives two pulses.
5. ch3 mode 11 with o_LEVEL high: i_ACK[3] pulsed. Expect o_PEND[3] stays 1 (set wins). After the level drops, i_ACK clears it.
6. Assert i_MRST_n=0 mid-run with o_PEND=4'b1011, asynchronously, between clock edges. Expect all outputs 0 immediately; after release, the first strobe occurs at the 4th tick.
